// File: rtl/array_2d_port_arbiter_pkg.sv
// Shared definitions for the two-requester 2D register array front end:
// controller state encoding and default geometry.
package array_2d_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam int ROW_W_DEF  = 3;
    localparam int COL_W_DEF  = 3;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/array_2d_port_arbiter_rr_arb2.sv
// Two-way round-robin grant. On contention the requester that did not win
// last time is served; last_grant resets to 1 so requester 0 wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/array_2d_port_arbiter.sv
// ROWS x COLS register array shared by two requesters, one access per cycle.
// Clears the whole array after reset or on clear_req; reads return next cycle.
module array_2d_port_arbiter
    import array_2d_ctrl_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int COL_W  = COL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_we,
    input  logic [2*ROW_W-1:0]  req_row,
    input  logic [2*COL_W-1:0]  req_col,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy
);

    localparam int ROWS  = 1 << ROW_W;
    localparam int COLS  = 1 << COL_W;
    localparam int CNT_W = ROW_W + COL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [0:ROWS-1][0:COLS-1];

    logic              arb_en;
    logic [1:0]        xfer;
    logic [1:0]        rd_xfer;
    logic              acc_sel;
    logic              acc_we;
    logic [ROW_W-1:0]  acc_row;
    logic [COL_W-1:0]  acc_col;
    logic [DATA_W-1:0] acc_wdata;
    logic [ROW_W-1:0]  clr_row;
    logic [COL_W-1:0]  clr_col;

    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            ST_SERVE: begin
                if (clear_req) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Handshake: a transfer happens at the edge where req_valid[i] && req_ready[i];
    // an ungranted requester keeps valid/address/data stable until it is granted.
    assign arb_en = (state_q == ST_SERVE) && !clear_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .enable (arb_en),
        .gnt    (req_ready)
    );

    assign xfer      = req_valid & req_ready;
    assign rd_xfer   = xfer & ~req_we;
    assign acc_sel   = req_ready[1];
    assign acc_we    = req_we[acc_sel];
    assign acc_row   = req_row[acc_sel*ROW_W +: ROW_W];
    assign acc_col   = req_col[acc_sel*COL_W +: COL_W];
    assign acc_wdata = req_wdata[acc_sel*DATA_W +: DATA_W];
    assign clr_row   = cnt_q[CNT_W-1:COL_W];
    assign clr_col   = cnt_q[COL_W-1:0];

    // Storage has no reset; the sweep that follows every reset re-zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_row][clr_col] <= '0;
        end else if (|xfer && acc_we) begin
            mem[acc_row][acc_col] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rd_xfer;
            if (|rd_xfer) rsp_data_q <= mem[acc_row][acc_col];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_array_2d_port_arbiter.sv
// Directed bench for array_2d_port_arbiter: sweep timing, arbitration order,
// read latency, clear command and mid-sweep reset.
module tb_array_2d_port_arbiter;

  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear_req;
  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [2*ROW_W-1:0]  req_row;
  logic [2*COL_W-1:0]  req_col;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_2d_port_arbiter #(
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input int row, input int col, input int data);
    req_valid[i] = v;
    req_we[i]    = we;
    req_row[i*ROW_W +: ROW_W]    = ROW_W'(row);
    req_col[i*COL_W +: COL_W]    = COL_W'(col);
    req_wdata[i*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
  endtask

  // Counts edges while busy, bounded; also notes any grant or response seen meanwhile.
  task automatic wait_sweep(output int n, output int rdy_seen, output int rsp_seen);
    n = 0;
    rdy_seen = 0;
    rsp_seen = 0;
    while (busy && n < 200) begin
      #2;
      if (req_ready !== 2'b00) rdy_seen++;
      if (rsp_valid !== 2'b00) rsp_seen++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, rdy_seen, rsp_seen;
    int j0, j1;
    int exp_g;
    int rd_row [4];
    int rd_col [4];
    int rd_dat [4];

    rst_n     = 1'b0;
    clear_req = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_row   = '0;
    req_col   = '0;
    req_wdata = '0;

    // Reset values
    repeat (3) cyc();
    settle();
    check("reset_busy", 32'(busy), 1);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_data", 32'(rsp_data), 0);
    check("reset_ready", 32'(req_ready), 0);

    // Initial sweep
    cyc();
    rst_n = 1'b1;
    wait_sweep(n, rdy_seen, rsp_seen);
    check("init_sweep_len", n, 64);
    check("init_sweep_ready", rdy_seen, 0);
    check("init_sweep_busy_low", 32'(busy), 0);

    // Read (7,7) by req 0 right after the sweep
    idle();
    set_req(0, 1'b1, 1'b0, 7, 7, 0);
    settle();
    check("rd77_ready", 32'(req_ready), 1);
    cyc();
    idle();
    settle();
    check("rd77_rsp_valid", 32'(rsp_valid), 1);
    check("rd77_rsp_data", 32'(rsp_data), 0);
    cyc();
    settle();
    check("rd77_rsp_one_cycle", 32'(rsp_valid), 0);

    // Req 0 writes A5 to (3,5); req 1 reads it back next cycle
    set_req(0, 1'b1, 1'b1, 3, 5, 8'hA5);
    settle();
    check("wr35_ready", 32'(req_ready), 1);
    cyc();
    set_req(0, 1'b0, 1'b0, 0, 0, 0);
    set_req(1, 1'b1, 1'b0, 3, 5, 0);
    settle();
    check("rd35_ready", 32'(req_ready), 2);
    check("wr35_no_rsp", 32'(rsp_valid), 0);
    cyc();
    idle();
    settle();
    check("rd35_rsp_valid", 32'(rsp_valid), 2);
    check("rd35_rsp_data", 32'(rsp_data), 32'hA5);

    // Both valid for 6 cycles: alternate grants starting with 0
    j0 = 0;
    j1 = 0;
    for (int c = 0; c < 6; c++) begin
      exp_g = (c % 2 == 0) ? 1 : 2;
      set_req(0, 1'b1, 1'b1, 4, j0, 8'h10 + j0);
      set_req(1, 1'b1, 1'b1, 5, j1, 8'h20 + j1);
      settle();
      check($sformatf("rr_grant_%0d", c), 32'(req_ready), exp_g);
      cyc();
      if (exp_g == 1) j0++;
      else j1++;
    end
    idle();

    // Req 1 alone reads 4 cells back-to-back
    rd_row = '{4, 4, 5, 5};
    rd_col = '{0, 2, 0, 2};
    rd_dat = '{8'h10, 8'h12, 8'h20, 8'h22};
    for (int c = 0; c < 4; c++) begin
      set_req(1, 1'b1, 1'b0, rd_row[c], rd_col[c], 0);
      settle();
      check($sformatf("burst_ready_%0d", c), 32'(req_ready), 2);
      if (c > 0) begin
        check($sformatf("burst_rsp_valid_%0d", c - 1), 32'(rsp_valid), 2);
        check($sformatf("burst_rsp_data_%0d", c - 1), 32'(rsp_data), rd_dat[c-1]);
      end
      cyc();
    end
    idle();
    settle();
    check("burst_rsp_valid_3", 32'(rsp_valid), 2);
    check("burst_rsp_data_3", 32'(rsp_data), rd_dat[3]);
    cyc();
    settle();
    check("burst_rsp_end", 32'(rsp_valid), 0);

    // Write 3C to (2,2), then clear while both requesters are valid
    set_req(0, 1'b1, 1'b1, 2, 2, 8'h3C);
    settle();
    check("wr22_ready", 32'(req_ready), 1);
    cyc();
    clear_req = 1'b1;
    set_req(0, 1'b1, 1'b0, 2, 2, 0);
    set_req(1, 1'b1, 1'b0, 2, 2, 0);
    settle();
    check("clear_no_grant", 32'(req_ready), 0);
    check("clear_busy_before", 32'(busy), 0);
    cyc();
    clear_req = 1'b0;
    check("clear_busy_after", 32'(busy), 1);
    wait_sweep(n, rdy_seen, rsp_seen);
    check("clear_sweep_len", n, 64);
    check("clear_sweep_ready", rdy_seen, 0);
    set_req(0, 1'b0, 1'b0, 0, 0, 0);
    set_req(1, 1'b1, 1'b0, 2, 2, 0);
    settle();
    check("rd22_ready", 32'(req_ready), 2);
    cyc();
    idle();
    settle();
    check("rd22_rsp_valid", 32'(rsp_valid), 2);
    check("rd22_cleared", 32'(rsp_data), 0);

    // Pending response dropped by reset; reset again at sweep count 20
    cyc();
    set_req(0, 1'b1, 1'b1, 4, 0, 8'h77);
    cyc();
    set_req(0, 1'b1, 1'b0, 4, 0, 0);
    cyc();
    idle();
    settle();
    check("pre_reset_rsp_valid", 32'(rsp_valid), 1);
    check("pre_reset_rsp_data", 32'(rsp_data), 32'h77);
    rst_n = 1'b0;
    #1;
    check("reset_drops_rsp", 32'(rsp_valid), 0);
    check("reset_rsp_data_zero", 32'(rsp_data), 0);
    check("reset_busy_again", 32'(busy), 1);
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    settle();
    check("mid_sweep_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_sweep_reset_rsp", 32'(rsp_valid), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_sweep(n, rdy_seen, rsp_seen);
    check("restart_sweep_len", n, 64);
    check("restart_sweep_rsp", rsp_seen, 0);
    check("restart_busy_low", 32'(busy), 0);
    settle();
    check("restart_no_rsp", 32'(rsp_valid), 0);

    // Cell 32 was past the aborted sweep; the full sweep must have cleared it
    set_req(0, 1'b1, 1'b0, 4, 0, 0);
    settle();
    check("rd40_ready", 32'(req_ready), 1);
    cyc();
    idle();
    settle();
    check("rd40_rsp_valid", 32'(rsp_valid), 1);
    check("rd40_cleared", 32'(rsp_data), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/array_2d_port_arbiter.md
# array_2d_port_arbiter

Two-requester front end for a ROWS x COLS two-dimensional register array. It owns the storage, clears every cell after reset or on command, and shares one access per cycle between requesters 0 and 1 under round-robin arbitration. Reads return registered data with a fixed 1-cycle latency. It sits between two client engines and the 2D array datapath, so neither client addresses the array directly.

## Interface
- ROW_W, 3, row address width; ROWS = 2**ROW_W
- COL_W, 3, column address width; COLS = 2**COL_W
- DATA_W, 8, cell width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear_req  in  1  level request to re-zero the whole array
- req_valid  in  2  per-requester access request
- req_we  in  2  per-requester write enable; 0 = read
- req_row  in  2*ROW_W  row address; requester i at [i*ROW_W +: ROW_W]
- req_col  in  2*COL_W  column address, same packing
- req_wdata  in  2*DATA_W  write data, same packing
- req_ready  out  2  grant; combinational, one-hot or zero
- rsp_valid  out  2  read data valid for requester i
- rsp_data  out  DATA_W  read data, shared by both requesters
- busy  out  1  high while clear sweep in progress

## Operation
- States: CLEAR, SERVE. Reset enters CLEAR with sweep counter 0 and last_grant = 1.
- CLEAR: each cycle writes 0 to cell (cnt / COLS, cnt % COLS), row-major, then cnt++. After the write of cell ROWS*COLS-1, go to SERVE and reset cnt to 0. req_ready = 0 throughout. clear_req is ignored in CLEAR.
- SERVE, clear_req = 1: no grant that cycle; go to CLEAR at the edge.
- SERVE, clear_req = 0, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant is updated on every grant.
- A transfer occurs when req_valid[i] && req_ready[i].
  - Write: the cell is updated at that edge.
  - Read: the cell is sampled into rsp_data and rsp_valid[i] is set for the next cycle.
- An ungranted requester holds valid, address and data stable until granted. Req_ready never depends on a requester's own later inputs.
- At most one array access per cycle, so there are no write/write or read/write collisions.
- Reset mid-sweep or mid-serve: storage is not reset; the new sweep rewrites every cell. Pending responses are dropped.

## Timing
- Reset values: busy = 1, rsp_valid = 0, rsp_data = 0, req_ready = 0, state CLEAR.
- Sweep: edge k (k = 0 .. ROWS*COLS-1) after rst_n rises writes cell k. busy falls after edge ROWS*COLS-1 (64 edges for default sizes). The first grant is possible in the cycle after that.
- Read latency: 1 cycle. Grant at edge n; rsp_valid[i] and rsp_data are valid after edge n and last exactly one cycle unless another read is granted.
- Read of a cell written by the previous grant returns the new value.
- Sustained throughput: one access per cycle. With both requesters continuously valid, grants alternate 0,1,0,1... starting with 0.
- clear_req asserted in SERVE: busy rises after the next edge. A full sweep of ROWS*COLS cycles follows.

## Structure
- Package array_2d_ctrl_pkg holds:
  - state encoding ST_CLEAR / ST_SERVE
  - default widths ROW_W_DEF = 3, COL_W_DEF = 3, DATA_W_DEF = 8
- Sub-module rr_arb2 holds the two-way round-robin grant logic and the last_grant register (inputs req[1:0], enable; output gnt[1:0]).
- Storage is a reg [DATA_W-1:0] mem [0:ROWS-1][0:COLS-1] in the top module. The sweep counter is ROW_W+COL_W bits.

## Test plan
- Reset, then wait 64 cycles. busy falls at edge 64; a read of (7,7) by req 0 returns 0 with rsp_valid[0] one cycle later.
- Req 0 writes 0xA5 to (3,5); next cycle req 1 reads (3,5). Expect rsp_valid[1] = 1 and rsp_data = 0xA5 one cycle after that grant.
- Both requesters valid for 6 cycles, writing distinct values to distinct cells. Expect grants 0,1,0,1,0,1; each requester's cells hold its own values.
- Write 0x3C to (2,2), then assert clear_req for one cycle while both requesters are valid. Expect no grant that cycle, busy = 1 for 64 cycles, and a read of (2,2) afterwards returns 0.
- Drop rst_n at sweep count 20, release it, and wait. Expect a full 64-cycle sweep from cell 0 and no rsp_valid pulse during or just after the reset.
- Req 1 alone valid, reading 4 cells back-to-back. Expect a grant every cycle, with rsp_valid[1] high for 4 consecutive cycles carrying the stored data in order.
